// File: rtl/block_counter.sv
`default_nettype none
// ============================================================================
//  Module   : block_counter
//  Purpose  : Produces the 32-bit ChaCha20 block counter word (state word 12)
//             from the number of keystream blocks already generated under the
//             current key/nonce.  The counter word is COUNTER_BASE plus
//             blocksproduced, registered once.  A sticky flag records that the
//             32-bit counter space has been overrun, so the nonce must not be
//             used any further.
//
//  Ports    : clk            in   1   system clock, rising-edge active
//             init           in   1   synchronous active-high reset
//             blocksproduced in  32   blocks already generated (sampled every
//                                     cycle, no handshake)
//             Block          out 32   registered counter word
//             last_block     out  1   registered; Block is 32'hFFFFFFFF
//             exhausted      out  1   sticky; counter space overrun
//
//  Params   : WIDTH          counter width, must be 32 (matches word_t)
//             COUNTER_BASE   initial block counter (RFC 8439 AEAD uses 1)
//
//  Options  : BLOCK_COUNTER_SATURATE_EN
//               undefined : Block wraps modulo 2^32 on overrun
//               defined   : Block sticks at 32'hFFFFFFFF on overrun
//
//  Revision : 1.0  initial release
// ============================================================================
module block_counter #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  COUNTER_BASE = 32'd0
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] blocksproduced,
  output logic [WIDTH-1:0] Block,
  output logic             last_block,
  output logic             exhausted
);

  // The counter word is one ChaCha20 state word; any other width would
  // silently break the state-matrix builder, so refuse to elaborate.
  generate
    if (WIDTH != 32) begin : g_width_check
      $error("block_counter: WIDTH must be 32, got %0d", WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // One extra bit so the carry out of the add is the overrun indication.
  logic [WIDTH:0]   sum33;
  logic             carry;
  logic [WIDTH-1:0] next_block;
  logic             next_last;

  always_comb begin
    sum33      = {1'b0, COUNTER_BASE} + {1'b0, blocksproduced};
    carry      = sum33[WIDTH];
    next_block = sum33[WIDTH-1:0];
`ifdef BLOCK_COUNTER_SATURATE_EN
    // Pin the word at the final legal counter instead of wrapping, so a
    // downstream consumer that ignores exhausted still never sees a reused
    // counter value.
    if (carry) begin
      next_block = ALL_ONES;
    end
`endif
    // Derived from the value actually loaded, so under saturation the flag
    // stays high along with the pinned word.
    next_last  = (next_block == ALL_ONES);
  end

  always_ff @(posedge clk) begin
    if (init) begin
      Block      <= '0;
      last_block <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      Block      <= next_block;
      last_block <= next_last;
      // Sticky: only init clears it, even if blocksproduced later drops.
      exhausted  <= exhausted | carry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_block_counter
//  Purpose  : Self-checking bench for block_counter.  Two instances share the
//             stimulus: one with COUNTER_BASE=0, one with COUNTER_BASE=1, so
//             the upper boundary and the wrap/overrun case are both covered.
//             A table of directed vectors is applied one per clock, followed
//             by a hand-written edge-sensitivity sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_block_counter;

  logic        clk;
  logic        init;
  logic [31:0] blocksproduced;
  logic [31:0] block0, block1;
  logic        last0, last1;
  logic        exh0, exh1;

  int checks = 0;
  int errors = 0;

  block_counter #(.WIDTH(32), .COUNTER_BASE(32'd0)) dut0 (
    .clk            (clk),
    .init           (init),
    .blocksproduced (blocksproduced),
    .Block          (block0),
    .last_block     (last0),
    .exhausted      (exh0)
  );

  block_counter #(.WIDTH(32), .COUNTER_BASE(32'd1)) dut1 (
    .clk            (clk),
    .init           (init),
    .blocksproduced (blocksproduced),
    .Block          (block1),
    .last_block     (last1),
    .exhausted      (exh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        init;
    logic [31:0] bp;
    logic [31:0] b0;
    logic        l0;
    logic        e0;
    logic [31:0] b1;
    logic        l1;
    logic        e1;
  } vec_t;

  vec_t vecs[$];

  // Wrap result of the base-1 instance for blocksproduced=FFFFFFFF.
`ifdef BLOCK_COUNTER_SATURATE_EN
  localparam logic [31:0] WRAP_BLOCK = 32'hFFFF_FFFF;
  localparam logic        WRAP_LAST  = 1'b1;
`else
  localparam logic [31:0] WRAP_BLOCK = 32'h0000_0000;
  localparam logic        WRAP_LAST  = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic [31:0] bp,
                     input logic [31:0] b0, input logic l0, input logic e0,
                     input logic [31:0] b1, input logic l1, input logic e1);
    vec_t v;
    v.init = i; v.bp = bp;
    v.b0 = b0; v.l0 = l0; v.e0 = e0;
    v.b1 = b1; v.l1 = l1; v.e1 = e1;
    vecs.push_back(v);
  endtask

  initial begin
    init           = 1'b1;
    blocksproduced = 32'd0;

    // Reset hold, including a non-zero input that must be ignored.
    for (int i = 0; i < 4; i++) add(1, 32'd0, 0, 0, 0, 0, 0, 0);
    add(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    // Count follow, each value held two cycles.
    add(0, 32'd1, 32'd1, 0, 0, 32'd2, 0, 0);
    add(0, 32'd1, 32'd1, 0, 0, 32'd2, 0, 0);
    add(0, 32'd2, 32'd2, 0, 0, 32'd3, 0, 0);
    add(0, 32'd2, 32'd2, 0, 0, 32'd3, 0, 0);
    add(0, 32'd3, 32'd3, 0, 0, 32'd4, 0, 0);
    add(0, 32'd3, 32'd3, 0, 0, 32'd4, 0, 0);
    // Upper boundary.
    add(0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 0, 0, 32'hFFFF_FFFE, 0, 0);
    add(0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFF, 1, 0);
    add(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, WRAP_BLOCK, WRAP_LAST, 1);
    // Overrun is sticky; going backwards is legal.
    add(0, 32'd5, 32'd5, 0, 0, 32'd6, 0, 1);
    add(0, 32'd3, 32'd3, 0, 0, 32'd4, 0, 1);
    add(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, WRAP_BLOCK, WRAP_LAST, 1);
    // Re-init mid-run clears everything from the first init edge.
    for (int i = 0; i < 5; i++) add(1, 32'd0, 0, 0, 0, 0, 0, 0);
    // First non-init edge reloads from blocksproduced.
    add(0, 32'd7, 32'd7, 0, 0, 32'd8, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      init           = vecs[i].init;
      blocksproduced = vecs[i].bp;
      @(posedge clk);
      #1;
      check($sformatf("v%0d block0", i), block0, vecs[i].b0);
      check($sformatf("v%0d last0",  i), {31'd0, last0}, {31'd0, vecs[i].l0});
      check($sformatf("v%0d exh0",   i), {31'd0, exh0},  {31'd0, vecs[i].e0});
      check($sformatf("v%0d block1", i), block1, vecs[i].b1);
      check($sformatf("v%0d last1",  i), {31'd0, last1}, {31'd0, vecs[i].l1});
      check($sformatf("v%0d exh1",   i), {31'd0, exh1},  {31'd0, vecs[i].e1});
    end

    // Edge sensitivity: an input change at the negedge must not reach the
    // outputs until the following posedge.
    @(negedge clk);
    blocksproduced = 32'h0000_0100;
    #1;
    check("edge mid block0", block0, 32'd7);
    check("edge mid block1", block1, 32'd8);
    #3;
    check("edge late block0", block0, 32'd7);
    @(posedge clk);
    #1;
    check("edge post block0", block0, 32'h0000_0100);
    check("edge post block1", block1, 32'h0000_0101);

    // Init asserted at a negedge takes effect at the next posedge only.
    @(negedge clk);
    init = 1'b1;
    blocksproduced = 32'h1234_5678;
    #1;
    check("init mid block0", block0, 32'h0000_0100);
    @(posedge clk);
    #1;
    check("init post block0", block0, 32'd0);
    check("init post block1", block1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/block_counter.md
Name: block_counter

Overview:
- Derives the 32-bit ChaCha20 block counter word (state word 12) from the number of keystream blocks already produced.
- Sits between the keystream sequencer, which supplies blocksproduced, and the ChaCha20 state-matrix builder, which consumes Block.
- Registered output with a sticky exhaustion flag, so a nonce is never reused past 2^32 blocks.

Parameters:
- COUNTER_BASE, 32'd0, initial block counter added to blocksproduced; RFC 8439 AEAD keystream uses 1, the bench uses 0.
- WIDTH, 32, counter width; fixed at 32 because it matches word_t. Any other value is a compile-time error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- init  input  1  reset; synchronous, active-high.
- blocksproduced  input  32  count of blocks already generated under the current key/nonce; sampled every cycle.
- Block  output  32 (word_t)  registered counter word = COUNTER_BASE + blocksproduced.
- last_block  output  1  registered; high when Block == 32'hFFFFFFFF, the final legal counter.
- exhausted  output  1  sticky; the counter space has been overrun.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (init).
- Reset (init=1 at a posedge):
  - Block <= 0, last_block <= 0, exhausted <= 0.
  - Outputs stay at these values for every cycle init is held.
  - blocksproduced is ignored while init=1.
- Normal operation (init=0), every posedge:
  - sum33 = {1'b0, COUNTER_BASE} + {1'b0, blocksproduced}.
  - Block <= sum33[31:0] (modulo 2^32 wrap).
  - last_block <= (sum33[31:0] == 32'hFFFFFFFF).
  - exhausted <= exhausted | sum33[32].
- Latency: exactly one cycle from blocksproduced to Block. No combinational path from any input to any output.
- No handshake: blocksproduced may change every cycle, and each value is reflected on the next edge.
- Wrap-around with COUNTER_BASE=0:
  - blocksproduced=32'hFFFFFFFF gives Block=32'hFFFFFFFF, last_block=1, exhausted unchanged.
  - With COUNTER_BASE=1, the same input gives Block=0 and sets exhausted.
- exhausted is cleared only by init. It stays 1 even if blocksproduced later drops back to a small value.
- blocksproduced moving backwards without init is legal: Block simply follows it.
- init mid-operation: takes effect on the next posedge regardless of blocksproduced; the first non-init edge reloads from blocksproduced.
- Power-up before the first init: outputs are undefined. Integrators must assert init for at least one edge.
- No X-propagation masking: an X on blocksproduced propagates to Block.

Optional Feature:
- Macro: BLOCK_COUNTER_SATURATE_EN.
- Defined:
  - When sum33[32]=1, Block <= 32'hFFFFFFFF instead of wrapping.
  - last_block stays 1.
  - exhausted is set as normal.
- Undefined: Block wraps modulo 2^32 as specified above.
- Everything else is identical in both builds.

Test Plan:
- Reset hold: init=1 for 5 cycles, blocksproduced=0 -> Block=0, last_block=0, exhausted=0 on every posedge.
- Count follow: init=0, blocksproduced 1, 2, 3, each held 2 cycles -> Block reads 1, 2, 3 one cycle after each change, exhausted=0.
- Upper boundary (COUNTER_BASE=0): blocksproduced 32'hFFFFFFFD, FFFFFFFE, FFFFFFFF -> Block follows one cycle later; last_block=1 only for FFFFFFFF; exhausted=0.
- Wrap (COUNTER_BASE=1): blocksproduced=32'hFFFFFFFF -> Block=0 and exhausted=1. Then blocksproduced=5 -> Block=6, exhausted still 1.
  - With BLOCK_COUNTER_SATURATE_EN defined, the same stimulus gives Block=32'hFFFFFFFF and exhausted=1.
- Re-init mid-run: blocksproduced=32'hFFFFFFFF with exhausted=1, then init=1 and blocksproduced=0 for 5 cycles -> Block=0, last_block=0, exhausted=0 from the first init edge.
- Edge sensitivity: change blocksproduced at the negedge -> Block changes only at the following posedge, never mid-cycle.
